// File: rtl/isp8_intr_ctrl.sv
// ---------------------------------------------------------------------------
// isp8_intr_ctrl
//   Interrupt controller for the isp8 I/O bus. Collects NUM_SRC peripheral
//   requests, each edge- or level-triggered and individually maskable.
//   Presents one prioritised request (bit 0 highest) on intr, exposes a
//   readable vector, and waits for an EOI write before re-requesting.
//
//   Register map (ext_addr[1:0], base decoded on ext_addr[15:2]):
//     0 PENDING  R/W1C (level-mode bits follow the source, W1C ignored)
//     1 MASK     RW, 1 = enabled
//     2 VECTOR   R {any_active, 4'b0, idx[2:0]}; any write = EOI
//     3 EDGECFG  RW, 1 = rising edge, 0 = level
//
//   Ports:
//     clk, rst            clock (rising edge), synchronous active-high reset
//     ext_addr[15:0]      core I/O address
//     ext_addr_cyc        address-cycle qualifier
//     ext_io_dout[7:0]    core write data
//     ext_io_wr/rd        core I/O write / read strobes
//     io_rdata[7:0]       read data, 0 when not read-selected (OR-mergeable)
//     intr                registered interrupt request to the core
//     intr_ack            one-cycle acknowledge from the core
//     irq_src[NUM_SRC]    peripheral request lines
//
//   Build option:
//     ISP8_INTC_SYNC_EN   defined   -> 2-flop synchroniser on every irq_src bit
//                         undefined -> irq_src used directly (must be
//                                      clk-synchronous)
// ---------------------------------------------------------------------------
module isp8_intr_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ext_addr,
  input  logic               ext_addr_cyc,
  input  logic [7:0]         ext_io_dout,
  input  logic               ext_io_wr,
  input  logic               ext_io_rd,
  output logic [7:0]         io_rdata,
  output logic               intr,
  input  logic               intr_ack,
  input  logic [NUM_SRC-1:0] irq_src
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] edgecfg_reg;
  logic [NUM_SRC-1:0] prev_reg;
  logic [2:0]         vec_reg, vec_next;

  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] edge_pending;
  logic [NUM_SRC-1:0] active;

  // 8-bit views of the NUM_SRC-wide registers; unimplemented bits read 0.
  logic [7:0] pending8, mask8, edgecfg8, active8;

  logic       sel, wr, rd;
  logic       wr_pending, wr_mask, wr_eoi, wr_edgecfg;
  logic       any_active;
  logic [2:0] idx;
  logic [2:0] vec_idx;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  assign sel = ext_addr_cyc && (ext_addr[15:2] == BASE_ADDR[15:2]);
  assign wr  = sel && ext_io_wr;
  assign rd  = sel && ext_io_rd;

  assign wr_pending = wr && (ext_addr[1:0] == 2'd0);
  assign wr_mask    = wr && (ext_addr[1:0] == 2'd1);
  assign wr_eoi     = wr && (ext_addr[1:0] == 2'd2);
  assign wr_edgecfg = wr && (ext_addr[1:0] == 2'd3);

  // ---------------------------------------------------------------------
  // Source conditioning
  // ---------------------------------------------------------------------
`ifdef ISP8_INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_src;
      sync2_reg <= sync1_reg;
    end
  end

  assign s = sync2_reg;
`else
  assign s = irq_src;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= s;
    end
  end

  assign rise = s & ~prev_reg;
  assign w1c  = wr_pending ? ext_io_dout[NUM_SRC-1:0] : '0;

  // Clear first, then OR in the new edge: a same-cycle edge beats W1C.
  assign edge_pending = (pending_reg & ~w1c) | rise;

  // Level-mode bits simply track the conditioned source.
  assign pending_next = (edgecfg_reg & edge_pending) | (~edgecfg_reg & s);

  assign active     = pending_reg & mask_reg;
  assign any_active = |active;

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      mask_reg    <= '0;
      edgecfg_reg <= '1;
    end else begin
      pending_reg <= pending_next;
      if (wr_mask) begin
        mask_reg <= ext_io_dout[NUM_SRC-1:0];
      end
      if (wr_edgecfg) begin
        edgecfg_reg <= ext_io_dout[NUM_SRC-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_SRC) begin : g_impl
        assign pending8[gi] = pending_reg[gi];
        assign mask8[gi]    = mask_reg[gi];
        assign edgecfg8[gi] = edgecfg_reg[gi];
        assign active8[gi]  = active[gi];
      end else begin : g_unimpl
        assign pending8[gi] = 1'b0;
        assign mask8[gi]    = 1'b0;
        assign edgecfg8[gi] = 1'b0;
        assign active8[gi]  = 1'b0;
      end
    end
  endgenerate

  // Lowest-numbered active source wins; scan from the top so bit 0 lands last.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active8[i]) begin
        idx = 3'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Request / service FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      vec_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    case (state_reg)
      IDLE: begin
        if (any_active) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // An ack always completes the handshake, even if the source was
        // cleared in the same cycle; the core already committed to service.
        if (intr_ack) begin
          state_next = SVC;
          vec_next   = idx;
        end else if (!any_active) begin
          state_next = IDLE;
        end
      end
      SVC: begin
        if (wr_eoi) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign intr = (state_reg == REQ);

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  assign vec_idx = (state_reg == SVC) ? vec_reg : idx;

  always_comb begin
    io_rdata = 8'h00;
    if (rd) begin
      case (ext_addr[1:0])
        2'd0:    io_rdata = pending8;
        2'd1:    io_rdata = mask8;
        2'd2:    io_rdata = {any_active, 4'b0000, vec_idx};
        default: io_rdata = edgecfg8;
      endcase
    end
  end

endmodule
